// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad entry path: matrix size, FSM
// encoding and the column priority encoder.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } kp_state_t;

  // Index of the lowest low (pressed) column; 0 when none is low.
  function automatic logic [1:0] col_to_idx(input logic [KP_COLS-1:0] col_n);
    col_to_idx = 2'd0;
    for (int i = KP_COLS - 1; i >= 0; i--) begin
      if (!col_n[i]) col_to_idx = i[1:0];
    end
  endfunction

  // One-hot active-low row drive for a row index.
  function automatic logic [KP_ROWS-1:0] row_drive(input logic [1:0] idx);
    row_drive = ~(KP_ROWS'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad columns.
// Resets to all-released so nothing looks pressed out of reset.
module keypad_col_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_async,
  output logic [3:0] col_s
);

  logic [3:0] col_meta;

  // Two-stage capture of the raw column levels.
  // NOTE: non-blocking assignments make both stages sample the old value on
  // the same edge; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
    end else begin
      col_meta <= col_async;
      col_s    <= col_meta;
    end
  end

endmodule

// File: rtl/hex_keypad_entry.sv
// Scans a 4x4 hex keypad, debounces presses and releases, and shifts each
// accepted key into an entry register that feeds the 8-digit hex display.
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int DIGITS          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key_col,
  input  logic                  clr,
  output logic [3:0]            key_row,
  output logic [4*DIGITS-1:0]   value,
  output logic [3:0]            key_code,
  output logic                  key_valid,
  output logic [3:0]            digit_count
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_DIV) ? DEBOUNCE_CYCLES : SCAN_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_TC   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_TC    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       DIGIT_MAX = 4'(DIGITS);

  logic [3:0]       col_s;
  kp_state_t        state, state_n;
  logic [1:0]       row_idx, row_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       lat_col, lat_col_n;
  logic             accept;
  logic [3:0]       code;

  keypad_col_sync u_col_sync (
    .clk       (clk),
    .rst       (rst),
    .col_async (key_col),
    .col_s     (col_s)
  );

  // Row index is held from detection through release, so it forms the code's upper half.
  assign code = {row_idx, col_to_idx(lat_col)};

  // FSM next-state: scan timing, press debounce and release debounce.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_n   = state;
    row_n     = row_idx;
    cnt_n     = cnt;
    lat_col_n = lat_col;
    accept    = 1'b0;
    unique case (state)
      ST_SCAN: begin
        if (cnt == SCAN_TC) begin
          cnt_n = '0;
          if (col_s != 4'hF) begin
            lat_col_n = col_s;
            state_n   = ST_DEBOUNCE;
          end else begin
            row_n = row_idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_DEBOUNCE: begin
        if (col_s != lat_col) begin
          cnt_n   = '0;
          row_n   = row_idx + 2'd1;
          state_n = ST_SCAN;
        end else if (cnt == DEB_TC) begin
          cnt_n   = '0;
          accept  = 1'b1;
          state_n = ST_HELD;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (col_s != 4'hF) begin
          cnt_n = '0;
        end else if (cnt == DEB_TC) begin
          cnt_n   = '0;
          row_n   = row_idx + 2'd1;
          state_n = ST_SCAN;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_SCAN;
      end
    endcase
  end

  // FSM state, scan counter and registered row drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_SCAN;
      row_idx <= 2'd0;
      cnt     <= '0;
      lat_col <= 4'hF;
      key_row <= row_drive(2'd0);
    end else begin
      state   <= state_n;
      row_idx <= row_n;
      cnt     <= cnt_n;
      lat_col <= lat_col_n;
      key_row <= row_drive(row_n);
    end
  end

  // Entry register and key outputs; clr beats a simultaneous accept for value/count.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      value       <= '0;
      digit_count <= 4'h0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= code;
      if (clr) begin
        value       <= '0;
        digit_count <= 4'h0;
      end else if (accept) begin
        value <= {value[4*DIGITS-5:0], code};
        if (digit_count != DIGIT_MAX) digit_count <= digit_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a keypad model that pulls the
// pressed key's column low only while its row is driven.
module tb_hex_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int DIGITS   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [31:0] value;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  digit_count;

  logic        pressed;
  logic [1:0]  prow;
  logic [1:0]  pcol;

  int errors   = 0;
  int checks   = 0;
  int kv_count = 0;
  int row_bad  = 0;

  always #5 clk = ~clk;

  hex_keypad_entry #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .DIGITS          (DIGITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_col     (key_col),
    .clr         (clr),
    .key_row     (key_row),
    .value       (value),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .digit_count (digit_count)
  );

  // Keypad matrix model.
  assign key_col = (pressed && !key_row[prow]) ? ~(4'b0001 << pcol) : 4'hF;

  // Count key_valid pulses and watch that exactly one row is driven low.
  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) kv_count++;
    if ($countones(key_row) != 3) row_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_kv(input int prev, input string tag);
    int n = 0;
    while (kv_count == prev && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept seen"}, 32'(kv_count != prev), 32'd1);
  endtask

  task automatic wait_row(input logic [3:0] row, input string tag);
    int n = 0;
    while (key_row !== row && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " row reached"}, 32'(key_row), 32'(row));
  endtask

  task automatic enter_key(input logic [3:0] code);
    int prev = kv_count;
    prow    = code[3:2];
    pcol    = code[1:0];
    pressed = 1'b1;
    wait_kv(prev, "enter");
    pressed = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int prev;
    rst = 1'b1; clr = 1'b0; pressed = 1'b0; prow = 2'd0; pcol = 2'd0;
    repeat (3) @(negedge clk);
    check("reset key_row", 32'(key_row), 32'h0000_000E);
    check("reset value", value, 32'h0);
    check("reset key_code", 32'(key_code), 32'h0);
    check("reset key_valid", 32'(key_valid), 32'h0);
    check("reset digit_count", 32'(digit_count), 32'h0);
    rst = 1'b0;

    // 1: clean press of row1/col2 (code 6).
    prev = kv_count;
    prow = 2'd1; pcol = 2'd2; pressed = 1'b1;
    wait_kv(prev, "t1");
    check("t1 key_valid", 32'(key_valid), 32'h1);
    check("t1 key_code", 32'(key_code), 32'h6);
    check("t1 value", value, 32'h6);
    check("t1 digit_count", 32'(digit_count), 32'h1);
    check("t1 row held", 32'(key_row), 32'hD);
    @(negedge clk);
    check("t1 pulse width", 32'(key_valid), 32'h0);
    repeat (40) @(negedge clk);
    pressed = 1'b0;
    repeat (30) @(negedge clk);
    check("t1 pulses", 32'(kv_count - prev), 32'd1);

    // 2: keys 1..9, oldest nibble lost, count saturates.
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    prev = kv_count;
    for (int k = 1; k <= 8; k++) enter_key(4'(k));
    check("t2 count at 8", 32'(digit_count), 32'h8);
    check("t2 value at 8", value, 32'h1234_5678);
    enter_key(4'h9);
    check("t2 value", value, 32'h2345_6789);
    check("t2 digit_count", 32'(digit_count), 32'h8);
    check("t2 pulses", 32'(kv_count - prev), 32'd9);

    // 3a: bouncing press then stable -> single accept after stable run.
    prev = kv_count;
    prow = 2'd2; pcol = 2'd2;
    for (int i = 0; i < 20; i++) begin
      pressed = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    check("t3 bounce no accept", 32'(kv_count - prev), 32'd0);
    pressed = 1'b1;
    wait_kv(prev, "t3");
    check("t3 key_code", 32'(key_code), 32'hA);
    pressed = 1'b0;
    repeat (30) @(negedge clk);
    check("t3 pulses", 32'(kv_count - prev), 32'd1);
    // 3b: 5-cycle glitch alone.
    prev = kv_count;
    prow = 2'd0; pcol = 2'd3; pressed = 1'b1;
    repeat (5) @(negedge clk);
    pressed = 1'b0;
    repeat (60) @(negedge clk);
    check("t3 glitch", 32'(kv_count - prev), 32'd0);

    // 4: long hold gives one pulse; re-press after release gives another.
    prev = kv_count;
    prow = 2'd0; pcol = 2'd0; pressed = 1'b1;
    wait_kv(prev, "t4");
    repeat (100) @(negedge clk);
    check("t4 hold pulses", 32'(kv_count - prev), 32'd1);
    check("t4 key_code", 32'(key_code), 32'h0);
    pressed = 1'b0;
    repeat (20) @(negedge clk);
    pressed = 1'b1;
    wait_kv(prev + 1, "t4 second");
    check("t4 second pulses", 32'(kv_count - prev), 32'd2);
    pressed = 1'b0;
    repeat (30) @(negedge clk);

    // 5: clr coincident with accept of key C.
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    enter_key(4'hA);
    enter_key(4'hB);
    check("t5 value before", value, 32'hAB);
    check("t5 count before", 32'(digit_count), 32'h2);
    prev = kv_count;
    prow = 2'd3; pcol = 2'd0; clr = 1'b1; pressed = 1'b1;
    wait_kv(prev, "t5");
    check("t5 key_valid", 32'(key_valid), 32'h1);
    check("t5 key_code", 32'(key_code), 32'hC);
    check("t5 value", value, 32'h0);
    check("t5 digit_count", 32'(digit_count), 32'h0);
    clr = 1'b0;
    pressed = 1'b0;
    repeat (30) @(negedge clk);

    // 6: reset during the third debounce cycle of key 5.
    enter_key(4'h7);
    check("t6 value before", value, 32'h7);
    prev = kv_count;
    prow = 2'd1; pcol = 2'd1;
    wait_row(4'b1110, "t6 row0");
    pressed = 1'b1;
    wait_row(4'b1101, "t6 row1");
    repeat (6) @(negedge clk);
    rst = 1'b1;
    pressed = 1'b0;
    @(negedge clk);
    check("t6 key_row", 32'(key_row), 32'hE);
    check("t6 value", value, 32'h0);
    check("t6 key_code", 32'(key_code), 32'h0);
    check("t6 key_valid", 32'(key_valid), 32'h0);
    check("t6 digit_count", 32'(digit_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("t6 no accept", 32'(kv_count - prev), 32'd0);

    check("row one-hot", 32'(row_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
